mem_lsu_seq: RTL

MEM_LSU_SEQ -- requirements
Module: mem_lsu_seq

---
 rtl/lsu_pkg.sv | 14 +
 rtl/mem_lsu_seq.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the byte-serial load/store unit.
//   lsu_state_e    : sequencer states (IDLE / XFER / RESP)
//   BYTES_PER_WORD : bytes moved per word request
package lsu_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/mem_lsu_seq.sv
// mem_lsu_seq -- word load/store sequencer in front of a byte-wide memory.
// A 4-byte big-endian word request is split into four single-byte memory
// accesses (one per clock), after which a response is held until consumed.
//
// Parameters: B (bits per byte), N (byte-address width, wraps modulo 2^N).
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         request handshake
//   req_we, req_addr, req_wdata request: write flag, MSB byte address, word
//   rsp_valid/rsp_ready         response handshake
//   rsp_rdata, rsp_err          read word (0 for writes), rejection flag
//   mem_addr, mem_we, mem_wdata byte-wide memory command (0 outside XFER)
//   mem_rdata                   combinational read data of mem_addr
//
// Build option: define MISALIGN_CHK_EN to reject requests whose address is
// not word aligned (error response, no memory access). Without it, rsp_err
// is tied low and misaligned words are moved byte-wise with address wrap.
//
// state | meaning
// IDLE  | ready for a request
// XFER  | moving byte idx (0 = most significant) to/from memory
// RESP  | response presented, waiting for rsp_ready

import lsu_pkg::*;

module mem_lsu_seq #(
    parameter int B = 8,
    parameter int N = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [N-1:0]                req_addr,
    input  logic [BYTES_PER_WORD*B-1:0] req_wdata,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [BYTES_PER_WORD*B-1:0] rsp_rdata,
    output logic                        rsp_err,
    output logic [N-1:0]                mem_addr,
    output logic                        mem_we,
    output logic [B-1:0]                mem_wdata,
    input  logic [B-1:0]                mem_rdata
);

    localparam int W = BYTES_PER_WORD * B;
    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    lsu_state_e     state_q, state_d;
    logic [N-1:0]   addr_q;
    logic           we_q;
    logic [W-1:0]   wdata_q;
    logic [W-1:0]   rdata_q;
    logic [1:0]     idx_q;
    logic [B-1:0]   wbyte;
    logic           misalign;

`ifdef MISALIGN_CHK_EN
    assign misalign = (req_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req_valid) state_d = misalign ? RESP : XFER;
            XFER: if (idx_q == LAST_IDX) state_d = RESP;
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Big-endian byte select: idx 0 is the most significant byte.
    always_comb begin
        wbyte = '0;
        case (idx_q)
            2'd0: wbyte = wdata_q[4*B-1:3*B];
            2'd1: wbyte = wdata_q[3*B-1:2*B];
            2'd2: wbyte = wdata_q[2*B-1:B];
            2'd3: wbyte = wdata_q[B-1:0];
            default: wbyte = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        we_q    <= req_we;
                        wdata_q <= req_wdata;
                        rdata_q <= '0;
                        idx_q   <= 2'd0;
                    end
                end
                XFER: begin
                    if (!we_q) begin
                        case (idx_q)
                            2'd0: rdata_q[4*B-1:3*B] <= mem_rdata;
                            2'd1: rdata_q[3*B-1:2*B] <= mem_rdata;
                            2'd2: rdata_q[2*B-1:B]   <= mem_rdata;
                            2'd3: rdata_q[B-1:0]     <= mem_rdata;
                            default: rdata_q <= rdata_q;
                        endcase
                    end
                    // Wraps 3 -> 0, leaving idx cleared for the next access.
                    idx_q <= idx_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef MISALIGN_CHK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state_q == IDLE && req_valid) begin
            err_q <= misalign;
        end
    end

    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (state_q == XFER) begin
            mem_addr = addr_q + N'(idx_q);
            mem_we   = we_q;
            if (we_q) mem_wdata = wbyte;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;

endmodule
